// File: rtl/pwm_pkg.sv
// pwm_pkg: shared capture state encoding and default sizing for the PWM capture block
package pwm_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} cap_state_e;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_TIMEOUT = 200000;
  localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control input, PWM pin and measurement results of the capture block
interface pwm_capture_if import pwm_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
  logic en;
  logic pwm_in;
  logic [CNT_W-1:0] ton_meas;
  logic [CNT_W-1:0] tp_meas;
  logic meas_valid;
  logic stuck;
  logic stuck_level;
  modport master (output en, pwm_in, input ton_meas, tp_meas, meas_valid, stuck, stuck_level);
  modport slave (input en, pwm_in, output ton_meas, tp_meas, meas_valid, stuck, stuck_level);
endinterface

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer plus previous-level flop giving level and edge strobes
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [2:0] r_s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_s <= '0;
    else r_s <= {r_s[1:0], i_d};
  assign o_level = r_s[1];
  assign o_rise = r_s[1] & ~r_s[2];
  assign o_fall = ~r_s[1] & r_s[2];
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM input in generator Ton/Tp encoding
module pwm_capture import pwm_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst_n,
  pwm_capture_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] TO = IDLE_W'(TIMEOUT);
  cap_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0] r_high, r_per, r_ton, r_tp, w_high_nxt, w_per_nxt;
  logic [IDLE_W-1:0] r_idle, w_idle_nxt;
  logic r_valid, r_stuck, r_slvl, w_pub, w_stuck_nxt, w_slvl_nxt;
  logic w_lvl, w_rise, w_fall, w_edge, w_timeout;
  sync_edge u_sync (.clk(clk), .rst_n(rst_n), .i_d(bus.pwm_in), .o_level(w_lvl), .o_rise(w_rise), .o_fall(w_fall));
  assign w_edge = w_rise | w_fall;
  assign w_timeout = !w_edge && r_idle == TO - 1'b1;
  // idle_cnt parks at TIMEOUT so a dead line raises stuck only once per quiet spell
  always_comb begin
    w_state_nxt = r_state;
    w_high_nxt = r_high;
    w_per_nxt = (r_per == MAX) ? r_per : r_per + 1'b1;
    w_idle_nxt = w_edge ? '0 : (r_idle == TO) ? r_idle : r_idle + 1'b1;
    w_pub = 1'b0;
    w_stuck_nxt = r_stuck;
    w_slvl_nxt = r_slvl;
    case (r_state)
      IDLE: begin
        w_state_nxt = WAIT_RISE;
        w_per_nxt = '0;
        w_idle_nxt = '0;
      end
      WAIT_RISE: ;
      MEAS_HIGH: begin
        w_high_nxt = (w_lvl && r_high != MAX) ? r_high + 1'b1 : r_high;
        w_state_nxt = w_fall ? MEAS_LOW : MEAS_HIGH;
      end
      MEAS_LOW: w_pub = w_rise;
    endcase
    if (r_state != IDLE && w_rise) begin
      w_state_nxt = MEAS_HIGH;
      w_high_nxt = CNT_W'(1);
      w_per_nxt = CNT_W'(1);
      w_stuck_nxt = 1'b0;
    end else if (r_state != IDLE && w_timeout) begin
      w_state_nxt = WAIT_RISE;
      w_stuck_nxt = 1'b1;
      w_slvl_nxt = w_lvl;
    end
    if (!bus.en) begin
      w_state_nxt = IDLE;
      w_high_nxt = '0;
      w_per_nxt = '0;
      w_idle_nxt = '0;
      w_stuck_nxt = 1'b0;
      w_pub = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_high <= '0;
      r_per <= '0;
      r_idle <= '0;
      r_ton <= '0;
      r_tp <= '0;
      r_valid <= 1'b0;
      r_stuck <= 1'b0;
      r_slvl <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_high <= w_high_nxt;
      r_per <= w_per_nxt;
      r_idle <= w_idle_nxt;
      r_valid <= w_pub;
      r_stuck <= w_stuck_nxt;
      r_slvl <= w_slvl_nxt;
      if (w_pub) begin
        r_ton <= r_high;
        r_tp <= r_per - 1'b1;
      end
    end
  assign bus.ton_meas = r_ton;
  assign bus.tp_meas = r_tp;
  assign bus.meas_valid = r_valid;
  assign bus.stuck = r_stuck;
  assign bus.stuck_level = r_slvl;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives PWM segments into a 32-bit and a 4-bit capture and checks against an edge-time model
module tb_pwm_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic pwm_in = 1'b0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit hist[0:8191];
  bit en_h[0:8191];
  typedef struct {
    bit active, have_rise, have_fall, stuck, slvl, mv;
    int t_rise, t_fall, ref_t;
    longint ton, tp;
  } model_t;
  model_t m[2];
  longint cmax[2] = '{64'hFFFF_FFFF, 15};
  pwm_capture_if #(.CNT_W(32)) bus0 ();
  pwm_capture_if #(.CNT_W(4)) bus1 ();
  assign bus0.en = en;
  assign bus0.pwm_in = pwm_in;
  assign bus1.en = en;
  assign bus1.pwm_in = pwm_in;
  pwm_capture #(.CNT_W(32), .TIMEOUT(50)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  pwm_capture #(.CNT_W(4), .TIMEOUT(50)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  always #5 clk = ~clk;
  function automatic longint sat(input longint x, input longint mx);
    return x > mx ? mx : x;
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask
  task automatic check_all();
    check("valid32", 64'(bus0.meas_valid), 64'(m[0].mv));
    check("ton32", 64'(bus0.ton_meas), m[0].ton);
    check("tp32", 64'(bus0.tp_meas), m[0].tp);
    check("stuck32", 64'(bus0.stuck), 64'(m[0].stuck));
    check("slvl32", 64'(bus0.stuck_level), 64'(m[0].slvl));
    check("valid4", 64'(bus1.meas_valid), 64'(m[1].mv));
    check("ton4", 64'(bus1.ton_meas), m[1].ton);
    check("tp4", 64'(bus1.tp_meas), m[1].tp);
    check("stuck4", 64'(bus1.stuck), 64'(m[1].stuck));
    check("slvl4", 64'(bus1.stuck_level), 64'(m[1].slvl));
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) m[i] = '{default: 0};
  endtask
  // One decision of the capture logic: the synchronized level seen in cycle d is the pin two cycles earlier
  task automatic decide(input int i, input int d);
    bit v, vp, rise, fall;
    v = d >= 2 ? hist[d-2] : 1'b0;
    vp = d >= 3 ? hist[d-3] : 1'b0;
    rise = v & ~vp;
    fall = ~v & vp;
    m[i].mv = 1'b0;
    if (!en_h[d]) begin
      m[i].active = 0;
      m[i].have_rise = 0;
      m[i].stuck = 0;
      m[i].ref_t = d;
    end else if (!m[i].active) begin
      m[i].active = 1;
      m[i].have_rise = 0;
      m[i].ref_t = d;
    end else if (rise) begin
      if (m[i].have_rise && m[i].have_fall) begin
        m[i].mv = 1'b1;
        m[i].ton = sat(longint'(m[i].t_fall - m[i].t_rise), cmax[i]);
        m[i].tp = sat(longint'(d - m[i].t_rise), cmax[i]) - 1;
      end
      m[i].have_rise = 1;
      m[i].have_fall = 0;
      m[i].t_rise = d;
      m[i].stuck = 0;
      m[i].ref_t = d;
    end else if (fall) begin
      if (m[i].have_rise && !m[i].have_fall) begin
        m[i].have_fall = 1;
        m[i].t_fall = d;
      end
      m[i].ref_t = d;
    end else if (d - m[i].ref_t == 50) begin
      m[i].stuck = 1;
      m[i].slvl = v;
      m[i].have_rise = 0;
    end
  endtask
  task automatic step(input bit p, input bit e);
    @(posedge clk);
    if (cyc > 0) for (int i = 0; i < 2; i++) decide(i, cyc - 1);
    #1;
    pwm_in = p;
    en = e;
    hist[cyc] = p;
    en_h[cyc] = e;
    @(negedge clk);
    check_all();
    cyc++;
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int k = 0; k < cyc - 1; k++) hist[k] = 1'b0;
    #1 rst_n = 1'b1;
  endtask
  // h high cycles out of every p; drop removes en exactly on one publishing rise, rnd sprinkles en drops
  task automatic seg(input int h, input int p, input int n, input bit drop, input bit rnd);
    bit pin, e, armed;
    armed = drop;
    for (int k = 0; k < n; k++) begin
      pin = (k % p) < h;
      e = rnd ? ($urandom_range(0, 30) != 0) : 1'b1;
      if (armed && k > 3 * p && hist[cyc-2] && !hist[cyc-3]) begin
        e = 1'b0;
        armed = 0;
      end
      step(pin, e);
    end
  endtask
  initial begin
    model_reset();
    #1 check_all();
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    seg(3, 10, 60, 0, 0);
    seg(1, 2, 30, 0, 0);
    seg(0, 10, 70, 0, 0);
    seg(4, 10, 40, 0, 0);
    seg(10, 10, 70, 0, 0);
    seg(3, 10, 25, 0, 0);
    do_reset();
    seg(3, 10, 40, 0, 0);
    seg(20, 40, 130, 0, 0);
    seg(3, 10, 60, 1, 0);
    seg(20, 40, 170, 1, 0);
    for (int r = 0; r < 10; r++) begin
      int p, h;
      p = $urandom_range(2, 20);
      h = $urandom_range(0, p);
      seg(h, p, $urandom_range(20, 90), 0, r[0]);
      if (r == 5) do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
